mbx_rx_fetch: RTL and testbench

- Receive-side AHB-lite master engine. Sits between a core's mailbox port and that core's local logic.
- On the mailbox transmit interrupt, it reads the mailbox DATA register and acknowledges via a STATUS write. It then buffers each received word in a local FIFO.
- The core pops received words instead of polling the mailbox.
- One instance per core. Its AHB master port drives that core's mailbox slave port.

---
 rtl/mbx_rx_fetch.sv | 235 +++++++++++++++++++++++
 tb/tb_mbx_rx_fetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbx_rx_fetch.sv
// ---------------------------------------------------------------------------------------------
// mbx_rx_fetch
//   Receive-side AHB-lite master. When the mailbox raises its transmit interrupt the engine
//   reads the mailbox DATA register. It then writes ACK_VALUE to STATUS and waits for the
//   interrupt to drop. Each received word goes into a first-word-fall-through FIFO that the
//   local core pops.
//
// Ports
//   hclk, hrst            clock, asynchronous active-high reset
//   rx_intr               mailbox transmit interrupt (level)
//   m_haddr .. m_hwdata   AHB-lite master request (NONSEQ/IDLE only, word size)
//   m_hrdata, m_hready,
//   m_hresp               AHB-lite slave response
//   rx_valid, rx_data     FIFO head (valid whenever the FIFO is not empty)
//   rx_pop                consume the head word
//   rx_count              FIFO occupancy
//   err, err_clr          sticky bus/timeout error flag and its clear
// ---------------------------------------------------------------------------------------------
module mbx_rx_fetch #(
    parameter logic [31:0] DATA_ADDR   = 32'h0000_0004,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0008,
    parameter logic [31:0] ACK_VALUE   = 32'h0000_0001,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CLR_TIMEOUT = 64
) (
    input  logic                          hclk,
    input  logic                          hrst,
    input  logic                          rx_intr,
    output logic [31:0]                   m_haddr,
    output logic [1:0]                    m_htrans,
    output logic                          m_hwrite,
    output logic [2:0]                    m_hsize,
    output logic [31:0]                   m_hwdata,
    input  logic [31:0]                   m_hrdata,
    input  logic                          m_hready,
    input  logic [1:0]                    m_hresp,
    output logic                          rx_valid,
    output logic [31:0]                   rx_data,
    input  logic                          rx_pop,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          err,
    input  logic                          err_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(CLR_TIMEOUT + 1);

    localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]    HRESP_OKAY    = 2'b00;
    localparam logic [CW-1:0] FULL_COUNT    = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST    = TW'(CLR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdD,
        StAckA,
        StAckD,
        StWaitClr
    } state_e;

    state_e          r_state, w_state_d;
    logic [1:0]      r_htrans, w_htrans_d;
    logic [31:0]     r_haddr, w_haddr_d;
    logic            r_hwrite, w_hwrite_d;
    logic [31:0]     r_hwdata, w_hwdata_d;
    logic [TW-1:0]   r_timer, w_timer_d;
    logic            r_err;
    logic            w_err_set;
    logic            w_push;
    logic            w_pop;
    logic            w_has_room;

    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;

    // A pop in the same cycle frees a slot, so a full FIFO can still start a fetch.
    assign w_pop      = rx_pop && (r_count != '0);
    assign w_has_room = (r_count != FULL_COUNT) || rx_pop;

    // ------------------------------------------------------------------
    // FSM next-state and bus request. Address-phase states spend one cycle
    // loading the request registers (htrans still IDLE), then hold NONSEQ
    // until the slave accepts it with m_hready=1.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state;
        w_htrans_d = r_htrans;
        w_haddr_d  = r_haddr;
        w_hwrite_d = r_hwrite;
        w_hwdata_d = r_hwdata;
        w_timer_d  = r_timer;
        w_push     = 1'b0;
        w_err_set  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (rx_intr && w_has_room) begin
                    w_state_d = StRdA;
                end
            end
            StRdA: begin
                if (r_htrans == HTRANS_IDLE) begin
                    w_htrans_d = HTRANS_NONSEQ;
                    w_haddr_d  = DATA_ADDR;
                    w_hwrite_d = 1'b0;
                end else if (m_hready) begin
                    w_htrans_d = HTRANS_IDLE;
                    w_state_d  = StRdD;
                end
            end
            StRdD: begin
                if (m_hready) begin
                    if (m_hresp == HRESP_OKAY) begin
                        w_push    = 1'b1;
                        w_state_d = StAckA;
                    end else begin
                        w_err_set = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StAckA: begin
                if (r_htrans == HTRANS_IDLE) begin
                    w_htrans_d = HTRANS_NONSEQ;
                    w_haddr_d  = STATUS_ADDR;
                    w_hwrite_d = 1'b1;
                end else if (m_hready) begin
                    w_htrans_d = HTRANS_IDLE;
                    w_hwrite_d = 1'b0;
                    w_hwdata_d = ACK_VALUE;
                    w_state_d  = StAckD;
                end
            end
            StAckD: begin
                if (m_hready) begin
                    w_hwdata_d = '0;
                    if (m_hresp == HRESP_OKAY) begin
                        w_timer_d = '0;
                        w_state_d = StWaitClr;
                    end else begin
                        w_err_set = 1'b1;
                        w_state_d = StIdle;
                    end
                end
            end
            StWaitClr: begin
                // Leaving before the interrupt drops would re-read the same word.
                if (!rx_intr) begin
                    w_state_d = StIdle;
                end else if (r_timer == TIMER_LAST) begin
                    w_err_set = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            r_state  <= StIdle;
            r_htrans <= HTRANS_IDLE;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hwdata <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_htrans <= w_htrans_d;
            r_haddr  <= w_haddr_d;
            r_hwrite <= w_hwrite_d;
            r_hwdata <= w_hwdata_d;
            r_timer  <= w_timer_d;
        end
    end

    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO: pointers wrap naturally because FIFO_DEPTH is a power of two.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= m_hrdata;
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_htrans = r_htrans;
    assign m_haddr  = r_haddr;
    assign m_hwrite = r_hwrite;
    assign m_hsize  = 3'b010;
    assign m_hwdata = r_hwdata;
    assign rx_valid = (r_count != '0);
    assign rx_data  = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign rx_count = r_count;
    assign err      = r_err;

endmodule

// File: tb/tb_mbx_rx_fetch.sv
// Bench for mbx_rx_fetch: a mailbox/AHB slave model plus a queue-based FIFO reference.
module tb_mbx_rx_fetch;

    localparam logic [31:0] DATA_ADDR   = 32'h0000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_0008;
    localparam logic [31:0] ACK_VALUE   = 32'h0000_0001;
    localparam int          DEPTH       = 8;
    localparam int          TIMEOUT     = 64;

    logic        hclk = 1'b0;
    logic        hrst;
    logic        rx_intr;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic [1:0]  m_hresp;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_pop;
    logic [3:0]  rx_count;
    logic        err;
    logic        err_clr;

    mbx_rx_fetch #(
        .DATA_ADDR   (DATA_ADDR),
        .STATUS_ADDR (STATUS_ADDR),
        .ACK_VALUE   (ACK_VALUE),
        .FIFO_DEPTH  (DEPTH),
        .CLR_TIMEOUT (TIMEOUT)
    ) dut (
        .hclk     (hclk),
        .hrst     (hrst),
        .rx_intr  (rx_intr),
        .m_haddr  (m_haddr),
        .m_htrans (m_htrans),
        .m_hwrite (m_hwrite),
        .m_hsize  (m_hsize),
        .m_hwdata (m_hwdata),
        .m_hrdata (m_hrdata),
        .m_hready (m_hready),
        .m_hresp  (m_hresp),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_pop   (rx_pop),
        .rx_count (rx_count),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 hclk = ~hclk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int viol = 0;
    int n_addr_rd = 0;
    int n_rd = 0;
    int n_wr = 0;
    int last_wr_cyc = 0;

    logic [31:0] model_q[$];   // expected FIFO contents
    logic [31:0] mb_q[$];      // messages pending in the mailbox
    bit          mb_enable = 1'b1;
    bit          stuck = 1'b0;
    bit          err_next_read = 1'b0;
    bit          rand_waits = 1'b0;
    int          wait_cfg = 0;
    int          gap = 0;
    bit          dp_active = 1'b0;
    bit          dp_write = 1'b0;
    int          waits_left = 0;
    logic [31:0] dp_addr = '0;

    // One clock: advance past the edge, then update the mailbox/slave model and reference FIFO.
    task automatic tick();
        logic [1:0]  p_htrans;
        logic [31:0] p_haddr;
        logic        p_hwrite;
        logic [31:0] p_hwdata;
        logic        p_hready;
        logic [1:0]  p_hresp;
        logic [31:0] p_hrdata;
        bit          p_pop;
        p_htrans = m_htrans;
        p_haddr  = m_haddr;
        p_hwrite = m_hwrite;
        p_hwdata = m_hwdata;
        p_hready = m_hready;
        p_hresp  = m_hresp;
        p_hrdata = m_hrdata;
        p_pop    = rx_pop && (model_q.size() > 0);
        @(posedge hclk);
        #1;
        cyc++;
        if (!p_hready && (m_htrans !== p_htrans)) viol++;
        if (!p_hready && p_htrans == 2'b10 && (m_haddr !== p_haddr || m_hwrite !== p_hwrite)) viol++;
        if (m_htrans !== 2'b00 && m_htrans !== 2'b10) viol++;
        if (m_hsize !== 3'b010) viol++;
        if (p_pop) void'(model_q.pop_front());
        if (dp_active && p_hready) begin
            dp_active = 1'b0;
            if (dp_write) begin
                n_wr++;
                last_wr_cyc = cyc;
                if (dp_addr !== STATUS_ADDR || p_hwdata !== ACK_VALUE) viol++;
                else if (!stuck && mb_q.size() > 0) begin
                    void'(mb_q.pop_front());
                    gap = 1;
                end
            end else begin
                n_rd++;
                if (dp_addr !== DATA_ADDR) viol++;
                if (p_hresp == 2'b00) model_q.push_back(p_hrdata);
                else begin
                    mb_enable = 1'b0;
                    err_next_read = 1'b0;
                end
            end
        end
        if (p_htrans == 2'b10 && p_hready) begin
            if (dp_active) viol++;
            dp_active  = 1'b1;
            dp_write   = p_hwrite;
            dp_addr    = p_haddr;
            waits_left = rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
            if (!p_hwrite) n_addr_rd++;
        end
        m_hresp  = 2'b00;
        m_hrdata = '0;
        if (dp_active && waits_left > 0) begin
            m_hready = 1'b0;
            waits_left--;
        end else begin
            m_hready = 1'b1;
            if (dp_active && !dp_write) begin
                m_hrdata = (mb_q.size() > 0) ? mb_q[0] : 32'hDEAD_BEEF;
                m_hresp  = err_next_read ? 2'b01 : 2'b00;
            end
        end
        if (gap > 0) begin
            rx_intr = 1'b0;
            gap--;
        end else begin
            rx_intr = mb_enable && (mb_q.size() > 0);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (m_htrans !== 2'b00) begin miscompares++; $display("FAIL reset_htrans got=%b exp=00", m_htrans); end
        vectors++; if (m_haddr !== 32'h0) begin miscompares++; $display("FAIL reset_haddr got=%h exp=0", m_haddr); end
        vectors++; if (m_hwrite !== 1'b0) begin miscompares++; $display("FAIL reset_hwrite got=%b exp=0", m_hwrite); end
        vectors++; if (m_hwdata !== 32'h0) begin miscompares++; $display("FAIL reset_hwdata got=%h exp=0", m_hwdata); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        vectors++; if (rx_count !== 4'd0) begin miscompares++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count); end
        vectors++; if (rx_data !== 32'h0) begin miscompares++; $display("FAIL reset_rx_data got=%h exp=0", rx_data); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
        tick();
        tick();
        hrst = 1'b0;
        repeat (3) tick();
    endtask

    // Shared body for the zero-wait and wait-state single-message scenarios.
    task automatic test_single_msg(input logic [31:0] word, input int waits);
        int t0, ra0, w0;
        wait_cfg = waits;
        ra0 = n_addr_rd;
        w0 = n_wr;
        mb_q.push_back(word);
        tick();
        t0 = cyc + 1;
        repeat (3 + waits) tick();
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL lat_early w%0d got=%b exp=0", waits, rx_valid); end
        tick();
        vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL lat_valid w%0d got=%b exp=1", waits, rx_valid); end
        vectors++; if (rx_data !== word) begin miscompares++; $display("FAIL lat_data w%0d got=%h exp=%h", waits, rx_data, word); end
        for (int i = 0; i < 40 && n_wr == w0; i++) tick();
        vectors++; if (last_wr_cyc != t0 + 6 + 2 * waits || n_wr != w0 + 1) begin
            miscompares++; $display("FAIL ack_done w%0d got=%0d exp=%0d", waits, last_wr_cyc - t0, 6 + 2 * waits); end
        repeat (8) tick();
        vectors++; if (n_addr_rd != ra0 + 1) begin miscompares++; $display("FAIL single_reads w%0d got=%0d exp=1", waits, n_addr_rd - ra0); end
        vectors++; if (int'(rx_count) != 1) begin miscompares++; $display("FAIL single_count w%0d got=%0d exp=1", waits, rx_count); end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        vectors++; if (rx_count !== 4'd0) begin miscompares++; $display("FAIL single_pop w%0d got=%0d exp=0", waits, rx_count); end
        wait_cfg = 0;
    endtask

    task automatic test_fifo_full();
        int ra, w0;
        logic [31:0] head;
        for (int i = 0; i < DEPTH + 1; i++) mb_q.push_back($urandom());
        for (int i = 0; i < 200 && model_q.size() < DEPTH; i++) tick();
        ra = n_addr_rd;
        repeat (20) tick();
        vectors++; if (n_addr_rd != ra) begin miscompares++; $display("FAIL full_no_fetch got=%0d exp=0", n_addr_rd - ra); end
        vectors++; if (int'(rx_count) != DEPTH) begin miscompares++; $display("FAIL full_count got=%0d exp=%0d", rx_count, DEPTH); end
        head = model_q[0];
        vectors++; if (rx_data !== head) begin miscompares++; $display("FAIL full_head got=%h exp=%h", rx_data, head); end
        w0 = n_wr;
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        for (int i = 0; i < 40 && n_wr == w0; i++) tick();
        vectors++; if (n_addr_rd != ra + 1) begin miscompares++; $display("FAIL full_resume got=%0d exp=1", n_addr_rd - ra); end
        vectors++; if (int'(rx_count) != DEPTH) begin miscompares++; $display("FAIL full_refill got=%0d exp=%0d", rx_count, DEPTH); end
        for (int i = 0; i < 3 * DEPTH && model_q.size() > 0; i++) begin
            vectors++; if (rx_data !== model_q[0]) begin miscompares++; $display("FAIL full_drain got=%h exp=%h", rx_data, model_q[0]); end
            rx_pop = 1'b1;
            tick();
            rx_pop = 1'b0;
        end
        vectors++; if (rx_count !== 4'd0) begin miscompares++; $display("FAIL full_empty got=%0d exp=0", rx_count); end
        repeat (4) tick();
    endtask

    task automatic test_err_resp();
        int r0, w0;
        r0 = n_rd;
        w0 = n_wr;
        err_next_read = 1'b1;
        mb_q.push_back(32'hBAD0_0BAD);
        for (int i = 0; i < 20 && n_rd == r0; i++) tick();
        repeat (10) tick();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL errresp_err got=%b exp=1", err); end
        vectors++; if (rx_count !== 4'd0) begin miscompares++; $display("FAIL errresp_nopush got=%0d exp=0", rx_count); end
        vectors++; if (n_wr != w0) begin miscompares++; $display("FAIL errresp_noack got=%0d exp=0", n_wr - w0); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL errresp_clr got=%b exp=0", err); end
        mb_enable = 1'b1;
        for (int i = 0; i < 40 && n_wr == w0; i++) tick();
        repeat (3) tick();
        vectors++; if (rx_data !== 32'hBAD0_0BAD || rx_count !== 4'd1) begin
            miscompares++; $display("FAIL errresp_retry got=%h/%0d exp=bad00bad/1", rx_data, rx_count); end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_stuck_intr();
        int w0, r0, tw;
        stuck = 1'b1;
        w0 = n_wr;
        mb_q.push_back(32'h5700_C4ED);
        for (int i = 0; i < 40 && n_wr == w0; i++) tick();
        tw = last_wr_cyc;
        r0 = n_rd;
        while (cyc < tw + TIMEOUT - 1) tick();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL stuck_early got=%b exp=0", err); end
        tick();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL stuck_timeout got=%b exp=1", err); end
        for (int i = 0; i < 20 && n_rd == r0; i++) tick();
        vectors++; if (n_rd != r0 + 1) begin miscompares++; $display("FAIL stuck_recover got=%0d exp=1", n_rd - r0); end
        stuck = 1'b0;
        w0 = n_wr;
        for (int i = 0; i < 40 && n_wr == w0; i++) tick();
        repeat (4) tick();
        vectors++; if (rx_count !== 4'd2) begin miscompares++; $display("FAIL stuck_count got=%0d exp=2", rx_count); end
        for (int i = 0; i < 4 && model_q.size() > 0; i++) begin
            vectors++; if (rx_data !== 32'h5700_C4ED) begin miscompares++; $display("FAIL stuck_data got=%h exp=5700c4ed", rx_data); end
            rx_pop = 1'b1;
            tick();
            rx_pop = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int w0;
        w0 = n_wr;
        mb_q.push_back(32'h0000_AAAA);
        for (int i = 0; i < 40 && n_wr == w0; i++) tick();
        repeat (3) tick();
        vectors++; if (rx_count !== 4'd1) begin miscompares++; $display("FAIL arst_pre got=%0d exp=1", rx_count); end
        wait_cfg = 6;
        mb_q.push_back(32'h0000_BBBB);
        for (int i = 0; i < 20 && !(dp_active && !dp_write); i++) tick();
        hrst = 1'b1;
        #1;
        vectors++; if (m_htrans !== 2'b00) begin miscompares++; $display("FAIL arst_htrans got=%b exp=00", m_htrans); end
        vectors++; if (rx_count !== 4'd0 || rx_valid !== 1'b0) begin
            miscompares++; $display("FAIL arst_fifo got=%0d/%b exp=0/0", rx_count, rx_valid); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL arst_err got=%b exp=0", err); end
        model_q.delete();
        dp_active = 1'b0;
        m_hready = 1'b1;
        m_hresp = 2'b00;
        wait_cfg = 0;
        tick();
        tick();
        hrst = 1'b0;
        w0 = n_wr;
        for (int i = 0; i < 40 && n_wr == w0; i++) tick();
        repeat (3) tick();
        vectors++; if (rx_count !== 4'd1 || rx_data !== 32'h0000_BBBB) begin
            miscompares++; $display("FAIL arst_after got=%0d/%h exp=1/0000bbbb", rx_count, rx_data); end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        int n;
        rand_waits = 1'b1;
        for (int i = 0; i < 24; i++) mb_q.push_back($urandom());
        n = 0;
        while (n < 4000 && (mb_q.size() > 0 || model_q.size() > 0 || dp_active)) begin
            rx_pop = ($urandom_range(0, 2) == 0);
            tick();
            n++;
            vectors++; if (int'(rx_count) != model_q.size()) begin
                miscompares++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, rx_count, model_q.size()); end
            vectors++; if (rx_valid !== (model_q.size() > 0)) begin
                miscompares++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, rx_valid, model_q.size() > 0); end
            if (model_q.size() > 0) begin
                vectors++; if (rx_data !== model_q[0]) begin
                    miscompares++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, rx_data, model_q[0]); end
            end
        end
        rx_pop = 1'b0;
        rand_waits = 1'b0;
        vectors++; if (mb_q.size() != 0 || model_q.size() != 0) begin
            miscompares++; $display("FAIL rand_drain got=%0d/%0d exp=0/0", mb_q.size(), model_q.size()); end
        repeat (4) tick();
    endtask

    task automatic test_protocol();
        vectors++; if (viol != 0) begin miscompares++; $display("FAIL ahb_protocol got=%0d exp=0", viol); end
    endtask

    initial begin
        hrst = 1'b1;
        rx_intr = 1'b0;
        m_hrdata = '0;
        m_hready = 1'b1;
        m_hresp = 2'b00;
        rx_pop = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_single_msg(32'hCAFE_0001, 0);
        test_single_msg(32'h1234_5678, 2);
        test_fifo_full();
        test_err_resp();
        test_stuck_intr();
        test_async_reset();
        test_random();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
